// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell
// walks WIDTH bits LSB first under a start/busy/done handshake.

module halfadder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c_q;

  logic s0;
  logic c0;
  logic sbit;
  logic c1;
  logic carry_next;
  logic accept;
  logic last;

  halfadder ha0 (
    .x (ra[0]),
    .y (rb[0]),
    .s (s0),
    .c (c0)
  );

  halfadder ha1 (
    .x (s0),
    .y (c_q),
    .s (sbit),
    .c (c1)
  );

  assign carry_next = c0 | c1;
  assign accept     = (state == IDLE) && start;
  assign last       = (state == RUN) && (cnt == LAST);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer: IDLE -> RUN for WIDTH edges -> DONE for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand/partial-sum shifters; result regs load only on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rs   <= '0;
      c_q  <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      ra  <= a;
      rb  <= b;
      rs  <= '0;
      c_q <= 1'b0;
    end else if (state == RUN) begin
      ra  <= {1'b0, ra[WIDTH-1:1]};
      rb  <= {1'b0, rb[WIDTH-1:1]};
      rs  <= {sbit, rs[WIDTH-1:1]};
      c_q <= carry_next;
      if (last) begin
        sum  <= {sbit, rs[WIDTH-1:1]};
        cout <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed + random checks of serial_adder_ctrl
// at WIDTH=8 and WIDTH=2 against plain a+b arithmetic.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int total = 0;
  int bad   = 0;

  logic [8:0] last8;
  logic [2:0] last2;

  serial_adder_ctrl #(.WIDTH(8)) d8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) d2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 transaction from IDLE; operands scrambled during RUN.
  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] want;
    want   = {1'b0, x} + {1'b0, y};
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("run8_busy", 32'(busy8), 1);
      chk("run8_done", 32'(done8), 0);
      chk("run8_hold", 32'({cout8, sum8}), 32'(last8));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      step();
    end
    chk("done8", 32'(done8), 1);
    chk("done8_busy", 32'(busy8), 0);
    chk("res8", 32'({cout8, sum8}), 32'(want));
    last8 = want;
    step();
    chk("done8_width", 32'(done8), 0);
    chk("idle8_busy", 32'(busy8), 0);
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] want;
    want   = {1'b0, x} + {1'b0, y};
    a2     = x;
    b2     = y;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("run2_busy", 32'(busy2), 1);
      chk("run2_done", 32'(done2), 0);
      chk("run2_hold", 32'({cout2, sum2}), 32'(last2));
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      step();
    end
    chk("done2", 32'(done2), 1);
    chk("done2_busy", 32'(busy2), 0);
    chk("res2", 32'({cout2, sum2}), 32'(want));
    last2 = want;
    step();
    chk("done2_width", 32'(done2), 0);
    chk("idle2_busy", 32'(busy2), 0);
  endtask

  initial begin
    int p;
    rst    = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    a8     = '0;
    b8     = '0;
    a2     = '0;
    b2     = '0;
    last8  = '0;
    last2  = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_res8", 32'({cout8, sum8}), 0);
    chk("rst_busy2", 32'(busy2), 0);
    chk("rst_res2", 32'({cout2, sum2}), 0);
    step();

    // basic, wrap, and max+max
    op8(8'h03, 8'h05);
    op8(8'hFF, 8'h01);
    op8(8'hFF, 8'hFF);
    op8(8'h00, 8'h00);

    // start in RUN and DONE is ignored
    a8     = 8'h10;
    b8     = 8'h20;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("ign_busy", 32'(busy8), 1);
      chk("ign_done", 32'(done8), 0);
      start8 = (i == 2);
      a8     = (i == 2) ? 8'hAA : 8'($urandom);
      b8     = (i == 2) ? 8'h55 : 8'($urandom);
      step();
    end
    chk("ign_donepulse", 32'(done8), 1);
    chk("ign_res", 32'({cout8, sum8}), 32'h030);
    last8  = 9'h030;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("ign_idle_busy", 32'(busy8), 0);
    chk("ign_idle_done", 32'(done8), 0);
    step();
    chk("ign_idle2_busy", 32'(busy8), 0);
    chk("ign_idle2_res", 32'({cout8, sum8}), 32'h030);

    // start held high: period WIDTH+2
    a8     = 8'h01;
    b8     = 8'h01;
    start8 = 1'b1;
    for (int e = 0; e < 30; e++) begin
      step();
      p = e % 10;
      chk("bb_busy", 32'(busy8), 32'(p < 8));
      chk("bb_done", 32'(done8), 32'(p == 8));
      if (p == 8) begin
        chk("bb_res", 32'({cout8, sum8}), 32'h002);
      end
    end
    start8 = 1'b0;
    last8  = 9'h002;
    step();
    chk("bb_stop", 32'(busy8), 0);

    // reset mid-RUN aborts
    op8(8'h03, 8'h05);
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    chk("abort_pre_busy", 32'(busy8), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_res", 32'({cout8, sum8}), 0);
    last8 = '0;
    last2 = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_nodone", 32'(done8), 0);
      chk("abort_nobusy", 32'(busy8), 0);
    end
    op8(8'h7F, 8'h01);

    // random sweeps
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom));
    end
    op2(2'd3, 2'd3);
    op2(2'd2, 2'd1);
    for (int i = 0; i < 1000; i++) begin
      op2(2'($urandom), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
